// File: rtl/kv_cache_pkg.sv
// Shared constants, FSM state type and address-split helpers for the L1 miss-refill path.
package kv_cache_pkg;

  localparam int unsigned WAYS       = 4;
  localparam int unsigned INDEX_W    = 4;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W      = ADDR_W - 2 - OFF_W - INDEX_W;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill,
    StTag
  } refill_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[2+OFF_W +: INDEX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[2 +: OFF_W];
  endfunction

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2+OFF_W], {(OFF_W + 2){1'b0}}};
  endfunction

endpackage

// File: rtl/kv_onehot_norm.sv
// Reduces an LRU kill mask to a strict one-hot: lowest set bit wins, an empty mask picks way 0.
module kv_onehot_norm #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] mask_i,
  output logic [W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (mask_i == '0) begin
      onehot_o[0] = 1'b1;
    end else begin
      // Two's-complement trick isolates the lowest set bit.
      onehot_o = mask_i & (~mask_i + W'(1));
    end
  end

endmodule

// File: rtl/kv_cache_refill.sv
// L1 miss-refill controller: latches victim way, bursts the line in, writes data then tag.
// Optional critical-word-first burst ordering via `KV_REFILL_CRITICAL_WORD_FIRST_EN.
module kv_cache_refill
  import kv_cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_miss_valid,
  output logic               o_miss_ready,
  input  logic [ADDR_W-1:0]  i_miss_addr,
  input  logic [WAYS-1:0]    i_killmask,
  output logic               o_mem_req_valid,
  input  logic               i_mem_req_ready,
  output logic [ADDR_W-1:0]  o_mem_req_addr,
  input  logic               i_mem_rvalid,
  input  logic [31:0]        i_mem_rdata,
  output logic               o_wr_en,
  output logic [WAYS-1:0]    o_wr_way,
  output logic [INDEX_W-1:0] o_wr_index,
  output logic [OFF_W-1:0]   o_wr_word,
  output logic [31:0]        o_wr_data,
  output logic               o_tag_wr_en,
  output logic [TAG_W-1:0]   o_tag,
  output logic [WAYS-1:0]    o_lru_hit,
  output logic               o_resp_valid,
  output logic [31:0]        o_resp_data,
  output logic               o_done
);

  refill_state_e state_q, state_d;

  logic [ADDR_W-1:0]  req_addr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [OFF_W-1:0]   off_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [WAYS-1:0]    way_q;
  logic               last_q;
  logic               wr_en_q;
  logic [OFF_W-1:0]   wr_word_q;
  logic [31:0]        wr_data_q;
  logic               resp_valid_q;
  logic [31:0]        resp_data_q;

  logic [WAYS-1:0]    victim;
  logic [ADDR_W-1:0]  miss_req_addr;
  logic [OFF_W-1:0]   start_off;
  logic [OFF_W-1:0]   beat_word;
  logic               accept;
  logic               beat;
  logic               beat_is_req;

  kv_onehot_norm #(
    .W(WAYS)
  ) u_victim_norm (
    .mask_i  (i_killmask),
    .onehot_o(victim)
  );

`ifdef KV_REFILL_CRITICAL_WORD_FIRST_EN
  assign miss_req_addr = word_align(i_miss_addr);
  assign start_off     = off_q;
`else
  assign miss_req_addr = line_align(i_miss_addr);
  assign start_off     = '0;
`endif

  assign accept      = (state_q == StIdle) && i_miss_valid;
  // last_q marks the spare cycle after the final beat, where further beats are dropped.
  assign beat        = (state_q == StFill) && !last_q && i_mem_rvalid;
  assign beat_word   = start_off + cnt_q;
  assign beat_is_req = (beat_word == off_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_miss_valid) state_d = StReq;
      StReq:   if (i_mem_req_ready) state_d = StFill;
      StFill:  if (last_q) state_d = StTag;
      StTag:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      way_q        <= '0;
      last_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_word_q    <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= beat;
      resp_valid_q <= beat && beat_is_req;
      if (accept) begin
        req_addr_q <= miss_req_addr;
        tag_q      <= addr_tag(i_miss_addr);
        index_q    <= addr_index(i_miss_addr);
        off_q      <= addr_offset(i_miss_addr);
        way_q      <= victim;
        cnt_q      <= '0;
        last_q     <= 1'b0;
      end
      if (beat) begin
        cnt_q     <= cnt_q + OFF_W'(1);
        wr_word_q <= beat_word;
        wr_data_q <= i_mem_rdata;
        if (cnt_q == OFF_W'(LINE_WORDS - 1)) last_q <= 1'b1;
        if (beat_is_req) resp_data_q <= i_mem_rdata;
      end
    end
  end

  // Ready is masked during reset so every output reads 0 until release.
  assign o_miss_ready    = (state_q == StIdle) && !i_rst;
  assign o_mem_req_valid = (state_q == StReq);
  assign o_mem_req_addr  = req_addr_q;
  assign o_wr_en         = wr_en_q;
  assign o_wr_way        = way_q;
  assign o_wr_index      = index_q;
  assign o_wr_word       = wr_word_q;
  assign o_wr_data       = wr_data_q;
  assign o_tag_wr_en     = (state_q == StTag);
  assign o_tag           = tag_q;
  assign o_lru_hit       = (state_q == StTag) ? way_q : '0;
  assign o_resp_valid    = resp_valid_q;
  assign o_resp_data     = resp_data_q;
  assign o_done          = (state_q == StTag);

endmodule

// File: tb/tb_kv_cache_refill.sv
// Self-checking bench for kv_cache_refill: scoreboard of expected data-array writes plus
// per-scenario timing checks of request, tag, LRU and done signalling.
module tb_kv_cache_refill;

`ifdef KV_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_miss_valid = 1'b0;
  logic        o_miss_ready;
  logic [31:0] i_miss_addr = '0;
  logic [3:0]  i_killmask = '0;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_wr_en;
  logic [3:0]  o_wr_way;
  logic [3:0]  o_wr_index;
  logic [1:0]  o_wr_word;
  logic [31:0] o_wr_data;
  logic        o_tag_wr_en;
  logic [23:0] o_tag;
  logic [3:0]  o_lru_hit;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        o_done;

  kv_cache_refill dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_miss_valid   (i_miss_valid),
    .o_miss_ready   (o_miss_ready),
    .i_miss_addr    (i_miss_addr),
    .i_killmask     (i_killmask),
    .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_addr (o_mem_req_addr),
    .i_mem_rvalid   (i_mem_rvalid),
    .i_mem_rdata    (i_mem_rdata),
    .o_wr_en        (o_wr_en),
    .o_wr_way       (o_wr_way),
    .o_wr_index     (o_wr_index),
    .o_wr_word      (o_wr_word),
    .o_wr_data      (o_wr_data),
    .o_tag_wr_en    (o_tag_wr_en),
    .o_tag          (o_tag),
    .o_lru_hit      (o_lru_hit),
    .o_resp_valid   (o_resp_valid),
    .o_resp_data    (o_resp_data),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  word;
    logic [31:0] data;
    logic [3:0]  way;
    logic [3:0]  index;
    logic        resp;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_count = 0;
  int  resp_count = 0;
  int  tag_count = 0;

  logic [139:0] all_out;
  assign all_out = {o_mem_req_valid, o_mem_req_addr, o_wr_en, o_wr_way, o_wr_index, o_wr_word,
                    o_wr_data, o_tag_wr_en, o_tag, o_lru_hit, o_resp_valid, o_resp_data, o_done,
                    o_miss_ready};

  // Scoreboard consumer: every data-array write must match the oldest expected beat.
  always @(negedge i_clk) begin : monitor
    wr_t e;
    wr_t got;
    if (!i_rst) begin
      if (o_wr_en) begin
        wr_count++;
        n_cmp++;
        got = {o_wr_word, o_wr_data, o_wr_way, o_wr_index, o_resp_valid};
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL wr_unexpected: got write %h, expected no write", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL wr_beat: got %h, expected %h (word,data,way,index,resp)", got, e);
          end
          if (o_resp_valid) begin
            resp_count++;
            n_cmp++;
            if (o_resp_data !== e.data) begin
              n_bad++;
              $display("FAIL resp_data: got %h, expected %h", o_resp_data, e.data);
            end
          end
        end
      end else if (o_resp_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_no_write: got o_resp_valid=1, expected 0 without o_wr_en");
      end
      if (o_tag_wr_en) tag_count++;
    end
  end

  task automatic tick;
    @(negedge i_clk);
    #1;
  endtask

  task automatic run_refill(input string name, input logic [31:0] addr, input logic [3:0] kill,
                            input logic [3:0] exp_way, input int stall, input logic [15:0] vpat,
                            input int vlen, input bit keep_valid, input logic [31:0] next_addr,
                            input logic [3:0] next_kill);
    logic [1:0]  off;
    logic [1:0]  start;
    logic [3:0]  idx;
    logic [23:0] tag;
    logic [31:0] exp_req;
    logic        v;
    wr_t         e;
    int          t;
    int          sent;
    int          k;
    int          wr0;
    int          resp0;
    int          tag0;
    off     = addr[3:2];
    idx     = addr[7:4];
    tag     = addr[31:8];
    exp_req = Cwf ? {addr[31:2], 2'b00} : {addr[31:4], 4'b0000};
    start   = Cwf ? off : 2'd0;
    wr0     = wr_count;
    resp0   = resp_count;
    tag0    = tag_count;

    t = 0;
    while (o_miss_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    n_cmp++;
    if (o_miss_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_timeout: got o_miss_ready=%b, expected 1", name, o_miss_ready);
      return;
    end

    i_miss_valid = 1'b1;
    i_miss_addr  = addr;
    i_killmask   = kill;
    tick();
    i_miss_valid = keep_valid;
    i_miss_addr  = next_addr;
    i_killmask   = next_kill;

    n_cmp++;
    if ({o_mem_req_valid, o_mem_req_addr, o_miss_ready} !== {1'b1, exp_req, 1'b0}) begin
      n_bad++;
      $display("FAIL %s req_start: got valid=%b addr=%h ready=%b, expected 1 %h 0", name,
               o_mem_req_valid, o_mem_req_addr, o_miss_ready, exp_req);
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      n_cmp++;
      if ({o_mem_req_valid, o_mem_req_addr} !== {1'b1, exp_req}) begin
        n_bad++;
        $display("FAIL %s req_hold: got valid=%b addr=%h, expected 1 %h", name,
                 o_mem_req_valid, o_mem_req_addr, exp_req);
      end
    end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    n_cmp++;
    if (o_mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s req_drop: got o_mem_req_valid=%b, expected 0", name, o_mem_req_valid);
    end

    sent = 0;
    k    = 0;
    while (sent < 4) begin
      v = (k < vlen) ? vpat[k] : 1'b1;
      i_mem_rvalid = v;
      i_mem_rdata  = $urandom;
      if (v) begin
        e.word  = start + 2'(sent);
        e.data  = i_mem_rdata;
        e.way   = exp_way;
        e.index = idx;
        e.resp  = (e.word == off);
        exp_q.push_back(e);
        sent++;
      end
      tick();
      k++;
    end
    i_mem_rvalid = 1'b0;

    n_cmp++;
    if ({o_wr_en, o_done, o_tag_wr_en} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s last_write: got wr_en,done,tag_wr=%b%b%b, expected 100", name,
               o_wr_en, o_done, o_tag_wr_en);
    end
    tick();
    n_cmp++;
    if ({o_done, o_tag_wr_en, o_lru_hit, o_tag, o_miss_ready, o_wr_en} !==
        {1'b1, 1'b1, exp_way, tag, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s tag_cycle: got done=%b tag_wr=%b hit=%b tag=%h ready=%b wr=%b, expected 1 1 %b %h 0 0",
               name, o_done, o_tag_wr_en, o_lru_hit, o_tag, o_miss_ready, o_wr_en, exp_way, tag);
    end
    tick();
    n_cmp++;
    if ({o_miss_ready, o_done, o_lru_hit, o_tag_wr_en} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL %s ready_return: got ready=%b done=%b hit=%b tag_wr=%b, expected 1 0 0000 0",
               name, o_miss_ready, o_done, o_lru_hit, o_tag_wr_en);
    end
    n_cmp++;
    if ({wr_count - wr0, resp_count - resp0, tag_count - tag0, exp_q.size()} !== {32'd4, 32'd1,
        32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL %s counts: got writes=%0d resps=%0d tags=%0d pending=%0d, expected 4 1 1 0",
               name, wr_count - wr0, resp_count - resp0, tag_count - tag0, exp_q.size());
    end
  endtask

  task automatic test_reset;
    tick();
    tick();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, expected all zero", all_out);
    end
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if (o_miss_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got o_miss_ready=%b, expected 1", o_miss_ready);
    end
    tick();
  endtask

  task automatic test_basic;
    run_refill("basic", 32'h0000_1234, 4'b0100, 4'b0100, 0, 16'hFFFF, 0, 1'b0, '0, '0);
  endtask

  task automatic test_victim_norm;
    run_refill("kill0110", 32'h0000_ABC8, 4'b0110, 4'b0010, 0, 16'hFFFF, 0, 1'b0, '0, '0);
    run_refill("kill0000", 32'h0001_0000, 4'b0000, 4'b0001, 0, 16'hFFFF, 0, 1'b0, '0, '0);
    run_refill("kill1000", 32'hFFFF_FFFC, 4'b1000, 4'b1000, 0, 16'hFFFF, 0, 1'b0, '0, '0);
  endtask

  task automatic test_backpressure;
    // rvalid pattern 1,0,0,1,1,0,1 (LSB first)
    run_refill("stall_gaps", 32'h0000_5678, 4'b0001, 4'b0001, 3, 16'h0059, 7, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_refill;
    wr_t e;
    int  tag0;
    int  wr0;
    tag0 = tag_count;
    i_miss_valid = 1'b1;
    i_miss_addr  = 32'h0000_2468;
    i_killmask   = 4'b0001;
    tick();
    i_miss_valid    = 1'b0;
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = $urandom;
      e.word  = (Cwf ? 2'd2 : 2'd0) + 2'(b);
      e.data  = i_mem_rdata;
      e.way   = 4'b0001;
      e.index = 4'h6;
      e.resp  = (e.word == 2'd2);
      exp_q.push_back(e);
      tick();
    end
    i_mem_rvalid = 1'b0;
    i_rst = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got %h, expected all zero", all_out);
    end
    tick();
    i_rst = 1'b0;
    tick();
    n_cmp++;
    if (tag_count !== tag0) begin
      n_bad++;
      $display("FAIL rst_mid_tag: got %0d tag writes, expected %0d", tag_count, tag0);
    end
    wr0 = wr_count;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hDEAD_BEEF;
    tick();
    tick();
    i_mem_rvalid = 1'b0;
    tick();
    n_cmp++;
    if ({wr_count - wr0, o_wr_en, o_miss_ready} !== {32'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_stray_beat: got writes=%0d wr_en=%b ready=%b, expected 0 0 1",
               wr_count - wr0, o_wr_en, o_miss_ready);
    end
    run_refill("after_reset", 32'h0000_2468, 4'b0010, 4'b0010, 0, 16'hFFFF, 0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back;
    // Valid stays high; the killmask seen during the first refill must not be captured.
    run_refill("b2b_first", 32'h0000_0F0C, 4'b0001, 4'b0001, 1, 16'h0005, 3, 1'b1,
               32'h0000_3390, 4'b0010);
    run_refill("b2b_second", 32'h0000_3390, 4'b1000, 4'b1000, 0, 16'hFFFF, 0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_victim_norm();
    test_backpressure();
    test_reset_mid_refill();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
